bp_inflight_queue: RTL and testbench

In-order queue of branch predictions in flight between IF and ID. At IF it captures the META chooser's final prediction and the GBP/LBP component predictions. At ID it retires the head entry against the resolved outcome and emits registered update commands for the GBP, LBP and META tables, plus a mispredict redirect. It replaces a fixed-delay shift register with an occupancy-tracked FIFO, so it tolerates bubbles and pipeline flushes.

---
 rtl/bp_inflight_queue_pkg.sv | 35 +++
 rtl/bp_inflight_queue_ram.sv | 28 ++
 rtl/bp_inflight_queue.sv | 187 ++++++++++++++++++
 tb/tb_bp_inflight_queue.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_inflight_queue_pkg.sv
// Shared definitions for the branch-prediction in-flight queue: entry layout,
// field offsets and the default depth.
package bp_inflight_queue_pkg;

    localparam int BPQ_ENTRY_W   = 35;
    localparam int BPQ_DEPTH_DEF = 8;
    localparam int BPQ_PC_LSB    = 0;
    localparam int BPQ_PRED_BIT  = 32;
    localparam int BPQ_GBP_BIT   = 33;
    localparam int BPQ_LBP_BIT   = 34;

    // Packed so that the bit positions line up with the offset constants above.
    typedef struct packed {
        logic        lbp_pred;
        logic        gbp_pred;
        logic        pred_taken;
        logic [31:0] pc;
    } bpq_entry_t;

    function automatic logic [BPQ_ENTRY_W-1:0] bpq_pack(
        input logic [31:0] pc,
        input logic        pred,
        input logic        gbp,
        input logic        lbp
    );
        logic [BPQ_ENTRY_W-1:0] e;
        e                      = '0;
        e[BPQ_PC_LSB +: 32]    = pc;
        e[BPQ_PRED_BIT]        = pred;
        e[BPQ_GBP_BIT]         = gbp;
        e[BPQ_LBP_BIT]         = lbp;
        return e;
    endfunction

endpackage

// File: rtl/bp_inflight_queue_ram.sv
// Entry storage for the in-flight queue: one synchronous write port and an
// asynchronous read port addressed by the read pointer.
module bpq_ram
    import bp_inflight_queue_pkg::*;
#(
    parameter int DEPTH = BPQ_DEPTH_DEF,
    parameter int PTR   = 3
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [PTR-1:0]         waddr,
    input  logic [BPQ_ENTRY_W-1:0] wdata,
    input  logic [PTR-1:0]         raddr,
    output logic [BPQ_ENTRY_W-1:0] rdata
);

    logic [BPQ_ENTRY_W-1:0] mem_q [DEPTH];

    // Entry write; contents are don't-care after reset so no reset branch.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/bp_inflight_queue.sv
// In-order queue of branch predictions between IF and ID with registered
// predictor update commands. Optional statistics counters under BPQ_STATS_EN.
module bp_inflight_queue
    import bp_inflight_queue_pkg::*;
#(
    parameter int DEPTH = BPQ_DEPTH_DEF,
    parameter int PTR   = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          push,
    input  logic [31:0]   if_pc,
    input  logic          pred_taken,
    input  logic          gbp_pred,
    input  logic          lbp_pred,
    input  logic          pop,
    input  logic [31:0]   id_pc,
    input  logic          is_branch,
    input  logic          is_taken,
    output logic          upd_valid,
    output logic [31:0]   upd_pc,
    output logic          upd_taken,
    output logic          meta_update,
    output logic          meta_up_down,
    output logic          mispredict,
    output logic          resync,
    output logic          full,
    output logic          empty,
    output logic [PTR:0]  count
`ifdef BPQ_STATS_EN
    ,
    output logic [31:0]   stat_branches,
    output logic [31:0]   stat_mispredicts
`endif
);

    localparam logic [PTR:0]   DEPTH_C = (PTR+1)'(DEPTH);
    localparam logic [PTR:0]   CNT_ONE = (PTR+1)'(1);
    localparam logic [PTR-1:0] PTR_ONE = PTR'(1);

    logic [PTR-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR:0]   count_q, count_d;
    logic           full_q, full_d, empty_q, empty_d;
    logic           upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
    logic [31:0]    upd_pc_q, upd_pc_d;
    logic           meta_update_q, meta_update_d, meta_up_down_q, meta_up_down_d;
    logic           mispredict_q, mispredict_d, resync_q, resync_d;

    logic [BPQ_ENTRY_W-1:0] rdata_s;
    bpq_entry_t             head_s;
    logic do_pop_s, match_s, retire_s, upd_s, mis_s, resync_s, flush_s, do_push_s;

    bpq_ram #(.DEPTH(DEPTH), .PTR(PTR)) u_ram (
        .clk   (clk),
        .we    (do_push_s),
        .waddr (wr_ptr_q),
        .wdata (bpq_pack(if_pc, pred_taken, gbp_pred, lbp_pred)),
        .raddr (rd_ptr_q),
        .rdata (rdata_s)
    );

    // Head compare, flush decision and next-state for pointers, count and outputs.
    always_comb begin
        head_s    = bpq_entry_t'(rdata_s);
        do_pop_s  = pop && !empty_q && !stall;
        match_s   = (id_pc == head_s.pc);
        retire_s  = do_pop_s && match_s;
        upd_s     = retire_s && is_branch;
        mis_s     = upd_s && (head_s.pred_taken ^ is_taken);
        resync_s  = do_pop_s && !match_s;
        flush_s   = mis_s || resync_s;
        // A retiring pop frees the slot this same edge, so a full queue can still accept.
        do_push_s = push && !stall && !flush_s && (!full_q || retire_s);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_s) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (retire_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, retire_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);

        upd_valid_d    = upd_s;
        mispredict_d   = mis_s;
        resync_d       = resync_s;
        meta_update_d  = upd_s && (head_s.gbp_pred ^ head_s.lbp_pred);
        upd_pc_d       = upd_pc_q;
        upd_taken_d    = upd_taken_q;
        meta_up_down_d = meta_up_down_q;
        if (upd_s) begin
            upd_pc_d       = head_s.pc;
            upd_taken_d    = is_taken;
            meta_up_down_d = is_taken ? head_s.gbp_pred : head_s.lbp_pred;
        end else begin
            upd_pc_d       = upd_pc_q;
            upd_taken_d    = upd_taken_q;
            meta_up_down_d = meta_up_down_q;
        end
    end

    // Queue state and registered update/redirect outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            upd_valid_q    <= 1'b0;
            upd_pc_q       <= 32'h0000_0000;
            upd_taken_q    <= 1'b0;
            meta_update_q  <= 1'b0;
            meta_up_down_q <= 1'b0;
            mispredict_q   <= 1'b0;
            resync_q       <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            upd_valid_q    <= upd_valid_d;
            upd_pc_q       <= upd_pc_d;
            upd_taken_q    <= upd_taken_d;
            meta_update_q  <= meta_update_d;
            meta_up_down_q <= meta_up_down_d;
            mispredict_q   <= mispredict_d;
            resync_q       <= resync_d;
        end
    end

    assign upd_valid    = upd_valid_q;
    assign upd_pc       = upd_pc_q;
    assign upd_taken    = upd_taken_q;
    assign meta_update  = meta_update_q;
    assign meta_up_down = meta_up_down_q;
    assign mispredict   = mispredict_q;
    assign resync       = resync_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign count        = count_q;

`ifdef BPQ_STATS_EN
    logic [31:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;

    // Counters advance on the same edge that raises the matching pulse.
    always_comb begin
        stat_br_d = upd_s ? (stat_br_q + 32'd1) : stat_br_q;
        stat_mp_d = mis_s ? (stat_mp_q + 32'd1) : stat_mp_q;
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_br_q <= 32'd0;
            stat_mp_q <= 32'd0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_bp_inflight_queue.sv
// Self-checking bench: queue-based reference model plus directed and random stimulus.
module tb_bp_inflight_queue;

    localparam int DEPTH = 8;

    logic        clk, reset, stall, push, pred_taken, gbp_pred, lbp_pred;
    logic        pop, is_branch, is_taken;
    logic [31:0] if_pc, id_pc;
    logic        upd_valid, upd_taken, meta_update, meta_up_down, mispredict, resync;
    logic        full, empty;
    logic [31:0] upd_pc;
    logic [3:0]  count;
`ifdef BPQ_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    bp_inflight_queue #(.DEPTH(DEPTH), .PTR(3)) dut (
        .clk(clk), .reset(reset), .stall(stall), .push(push), .if_pc(if_pc),
        .pred_taken(pred_taken), .gbp_pred(gbp_pred), .lbp_pred(lbp_pred),
        .pop(pop), .id_pc(id_pc), .is_branch(is_branch), .is_taken(is_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .meta_update(meta_update), .meta_up_down(meta_up_down),
        .mispredict(mispredict), .resync(resync), .full(full), .empty(empty),
        .count(count)
`ifdef BPQ_STATS_EN
        , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        bit          pred;
        bit          gbp;
        bit          lbp;
    } ent_t;

    ent_t        m_q[$];
    bit          m_uv, m_ut, m_mu, m_md, m_mis, m_rs;
    logic [31:0] m_upc;
    int          m_br, m_mp;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        m_q.delete();
        m_uv = 1'b0; m_ut = 1'b0; m_mu = 1'b0; m_md = 1'b0; m_mis = 1'b0; m_rs = 1'b0;
        m_upc = 32'h0; m_br = 0; m_mp = 0;
    endtask

    task automatic compare_all();
        chk("count", 32'(count), 32'(m_q.size()));
        chk("full", 32'(full), 32'(m_q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(m_q.size() == 0));
        chk("upd_valid", 32'(upd_valid), 32'(m_uv));
        chk("mispredict", 32'(mispredict), 32'(m_mis));
        chk("resync", 32'(resync), 32'(m_rs));
        chk("meta_update", 32'(meta_update), 32'(m_mu));
        if (m_uv) begin
            chk("upd_pc", upd_pc, m_upc);
            chk("upd_taken", 32'(upd_taken), 32'(m_ut));
            chk("meta_up_down", 32'(meta_up_down), 32'(m_md));
        end
`ifdef BPQ_STATS_EN
        chk("stat_branches", stat_branches, 32'(m_br));
        chk("stat_mispredicts", stat_mispredicts, 32'(m_mp));
`endif
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input bit s, input bit ps, input logic [31:0] pc, input bit pr,
                        input bit g, input bit l, input bit pp, input logic [31:0] ipc,
                        input bit br, input bit tk);
        ent_t h;
        bit   flush;
        stall = s; push = ps; if_pc = pc; pred_taken = pr; gbp_pred = g; lbp_pred = l;
        pop = pp; id_pc = ipc; is_branch = br; is_taken = tk;
        m_uv = 1'b0; m_mu = 1'b0; m_mis = 1'b0; m_rs = 1'b0;
        if (!s) begin
            flush = 1'b0;
            if (pp && m_q.size() > 0) begin
                h = m_q[0];
                if (ipc == h.pc) begin
                    void'(m_q.pop_front());
                    if (br) begin
                        m_uv  = 1'b1;
                        m_upc = h.pc;
                        m_ut  = tk;
                        m_mu  = h.gbp != h.lbp;
                        m_md  = tk ? h.gbp : h.lbp;
                        m_mis = h.pred != tk;
                        m_br++;
                        if (m_mis) m_mp++;
                        flush = m_mis;
                    end
                end else begin
                    m_rs  = 1'b1;
                    flush = 1'b1;
                end
            end
            if (flush) m_q.delete();
            else if (ps && m_q.size() < DEPTH) m_q.push_back('{pc, pr, g, l});
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        stall = 1'b0; push = 1'b0; if_pc = 32'h0; pred_taken = 1'b0; gbp_pred = 1'b0;
        lbp_pred = 1'b0; pop = 1'b0; id_pc = 32'h0; is_branch = 1'b0; is_taken = 1'b0;
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic async_reset();
        idle_inputs();
        reset = 1'b0;
        #1;
        mdl_reset();
        chk("rst_upd_valid", 32'(upd_valid), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        compare_all();
        #2;
        reset = 1'b1;
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [31:0] rpc, ipc;
        bit          tk;
        idle_inputs();
        mdl_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_count", 32'(count), 32'h0);
        chk("reset_empty", 32'(empty), 32'h1);
        chk("reset_full", 32'(full), 32'h0);
        chk("reset_upd_pc", upd_pc, 32'h0);
        compare_all();
        reset = 1'b1;
        @(negedge clk);

        // Correct taken prediction with disagreeing components.
        step(0, 1, 32'h100, 1, 1, 0, 0, 32'h0, 0, 0);
        chk("t1_count", 32'(count), 32'h1);
        step(0, 0, 32'h0, 0, 0, 0, 1, 32'h100, 1, 1);
        chk("t1_upd_valid", 32'(upd_valid), 32'h1);
        chk("t1_upd_pc", upd_pc, 32'h100);
        chk("t1_meta_update", 32'(meta_update), 32'h1);
        chk("t1_meta_up_down", 32'(meta_up_down), 32'h1);
        chk("t1_mispredict", 32'(mispredict), 32'h0);

        // Mispredict with three younger entries flushes them all.
        step(0, 1, 32'h200, 0, 0, 0, 0, 32'h0, 0, 0);
        for (int i = 1; i < 4; i++) step(0, 1, 32'h200 + 32'(4*i), 0, 0, 0, 0, 32'h0, 0, 0);
        chk("t2_count4", 32'(count), 32'h4);
        step(0, 1, 32'h2f0, 0, 0, 0, 1, 32'h200, 1, 1);
        chk("t2_mispredict", 32'(mispredict), 32'h1);
        chk("t2_meta_update", 32'(meta_update), 32'h0);
        chk("t2_count0", 32'(count), 32'h0);
        chk("t2_empty", 32'(empty), 32'h1);

        // PC mismatch at ID.
        step(0, 1, 32'h300, 1, 0, 0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0, 0, 1, 32'h304, 1, 1);
        chk("t3_resync", 32'(resync), 32'h1);
        chk("t3_upd_valid", 32'(upd_valid), 32'h0);
        chk("t3_empty", 32'(empty), 32'h1);

        // Fill, overflow, push+pop while full, then drain in order.
        for (int i = 0; i < 8; i++) step(0, 1, 32'h400 + 32'(4*i), 0, 0, 1, 0, 32'h0, 0, 0);
        chk("t4_full", 32'(full), 32'h1);
        chk("t4_count8", 32'(count), 32'h8);
        step(0, 1, 32'h420, 0, 0, 1, 0, 32'h0, 0, 0);
        chk("t4_drop_count", 32'(count), 32'h8);
        step(0, 1, 32'h500, 0, 0, 1, 1, 32'h400, 0, 0);
        chk("t4_pushpop_count", 32'(count), 32'h8);
        for (int i = 1; i < 8; i++) step(0, 0, 32'h0, 0, 0, 0, 1, 32'h400 + 32'(4*i), 0, 0);
        step(0, 0, 32'h0, 0, 0, 0, 1, 32'h500, 1, 0);
        chk("t4_wrap_upd_pc", upd_pc, 32'h500);
        chk("t4_wrap_meta_up_down", 32'(meta_up_down), 32'h1);
        chk("t4_wrap_mispredict", 32'(mispredict), 32'h0);
        chk("t4_empty", 32'(empty), 32'h1);

        // Stall freezes the queue; the pop proceeds once released.
        step(0, 1, 32'h600, 1, 1, 1, 0, 32'h0, 0, 0);
        step(1, 1, 32'h604, 1, 1, 1, 1, 32'h600, 1, 1);
        chk("t5_stall_count", 32'(count), 32'h1);
        chk("t5_stall_upd_valid", 32'(upd_valid), 32'h0);
        step(0, 0, 32'h0, 0, 0, 0, 1, 32'h600, 1, 1);
        chk("t5_upd_valid", 32'(upd_valid), 32'h1);
        chk("t5_upd_pc", upd_pc, 32'h600);

        // Reset with entries in flight.
        step(0, 1, 32'h700, 1, 1, 1, 0, 32'h0, 0, 0);
        step(0, 1, 32'h704, 1, 1, 1, 0, 32'h0, 0, 0);
        async_reset();
        chk("t6_count", 32'(count), 32'h0);

        // Five branches, the first two mispredicted.
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 32'h800 + 32'(16*i), 1, 1, 0, 0, 32'h0, 0, 0);
            step(0, 0, 32'h0, 0, 0, 0, 1, 32'h800 + 32'(16*i), 1, (i >= 2));
        end
`ifdef BPQ_STATS_EN
        chk("t7_stat_branches", stat_branches, 32'd5);
        chk("t7_stat_mispredicts", stat_mispredicts, 32'd2);
`endif
        // Reset while an update pulse is visible.
        step(0, 1, 32'h900, 1, 1, 0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0, 0, 1, 32'h900, 1, 1);
        chk("t8_pulse_before", 32'(upd_valid), 32'h1);
        async_reset();
`ifdef BPQ_STATS_EN
        chk("t8_stat_branches", stat_branches, 32'd0);
`endif

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rpc = $urandom() & 32'hffff_fffc;
            if (m_q.size() > 0 && $urandom_range(99) < 85) ipc = m_q[0].pc;
            else ipc = $urandom() & 32'hffff_fffc;
            if (m_q.size() > 0 && $urandom_range(99) < 85) tk = m_q[0].pred;
            else tk = 1'($urandom_range(1));
            step(($urandom_range(99) < 10), ($urandom_range(99) < 60), rpc,
                 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 ($urandom_range(99) < 45), ipc, ($urandom_range(99) < 70), tk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
